rom_read_arbiter: RTL and testbench

//   Shares one combinational-read lookup ROM (2N-bit address, 2N-bit data) between two requesters.

---
 rtl/rom_ctrl_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 16 +
 rtl/rom_read_arbiter.sv | 93 +++++++++
 tb/tb_rom_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM read controllers: FSM encoding, requester
// indices and the address-width helper.
package rom_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        RESP  = ST_RESP
    } state_t;

    function automatic int addr_w(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; prio names the requester that
// wins when both are valid.
module rr_arb2
    import rom_ctrl_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 && (!valid1 || prio == REQ0);
    assign gnt1 = valid1 && (!valid0 || prio == REQ1);

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational-read ROM between two requesters, one read in
// flight at a time, with registered read data and round-robin fairness.
module rom_read_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int N       = 2,
    parameter bit RR_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid0,
    input  logic [2*N-1:0] req_addr0,
    output logic           req_ready0,
    output logic           resp_valid0,
    input  logic           resp_ready0,
    output logic [2*N-1:0] resp_data0,
    input  logic           req_valid1,
    input  logic [2*N-1:0] req_addr1,
    output logic           req_ready1,
    output logic           resp_valid1,
    input  logic           resp_ready1,
    output logic [2*N-1:0] resp_data1,
    output logic [2*N-1:0] rom_address,
    output logic           rom_en,
    output logic           rom_read_en,
    input  logic [2*N-1:0] rom_data
);

    localparam int AW = addr_w(N);

    state_t          state_q, state_d;
    logic            prio_q;
    logic            win_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   resp_q;
    logic            gnt0, gnt1;
    logic            accept;
    logic            resp_done;

    rr_arb2 u_arb (
        .valid0 (req_valid0),
        .valid1 (req_valid1),
        .prio   (prio_q),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // Grants only count in IDLE; a held response therefore blocks new requests.
    assign req_ready0 = (state_q == IDLE) && gnt0;
    assign req_ready1 = (state_q == IDLE) && gnt1;
    assign accept     = req_ready0 || req_ready1;

    assign resp_valid0 = (state_q == RESP) && (win_q == REQ0);
    assign resp_valid1 = (state_q == RESP) && (win_q == REQ1);
    assign resp_data0  = resp_q;
    assign resp_data1  = resp_q;
    assign resp_done   = (resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1);

    assign rom_en      = (state_q == ISSUE);
    assign rom_read_en = (state_q == ISSUE);
    assign rom_address = (state_q == ISSUE) ? addr_q : '0;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= RR_INIT;
            win_q   <= REQ0;
            addr_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                win_q  <= gnt1;
                addr_q <= gnt1 ? req_addr1 : req_addr0;
            end
            if (state_q == ISSUE) resp_q <= rom_data;
            if (resp_done) prio_q <= ~win_q;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter in front of a ROM holding mem[a] = a ^ 4'hA.
module tb_rom_read_arbiter;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid0, req_valid1;
    logic [3:0] req_addr0, req_addr1;
    logic       req_ready0, req_ready1;
    logic       resp_valid0, resp_valid1;
    logic       resp_ready0, resp_ready1;
    logic [3:0] resp_data0, resp_data1;
    logic [3:0] rom_address;
    logic       rom_en, rom_read_en;
    logic [3:0] rom_data;

    logic [3:0] rom_mem [16];

    int errors = 0;
    int checks = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         served[$];
    bit         soak_done;

    always #5 clk = ~clk;

    rom_read_arbiter #(.N(N), .RR_INIT(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid0  (req_valid0),
        .req_addr0   (req_addr0),
        .req_ready0  (req_ready0),
        .resp_valid0 (resp_valid0),
        .resp_ready0 (resp_ready0),
        .resp_data0  (resp_data0),
        .req_valid1  (req_valid1),
        .req_addr1   (req_addr1),
        .req_ready1  (req_ready1),
        .resp_valid1 (resp_valid1),
        .resp_ready1 (resp_ready1),
        .resp_data1  (resp_data1),
        .rom_address (rom_address),
        .rom_en      (rom_en),
        .rom_read_en (rom_read_en),
        .rom_data    (rom_data)
    );

    initial begin
        for (int a = 0; a < 16; a++) rom_mem[a] = 4'(a) ^ 4'hA;
    end

    always_comb begin
        rom_data = '0;
        if (rom_en && rom_read_en) rom_data = rom_mem[rom_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected word whenever a response handshake completes.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid0 || resp_valid1)
                check("resp_onehot", 32'(resp_valid0 & resp_valid1), 0);
            if (resp_valid0 && resp_ready0) begin
                if (q0.size() == 0) check("unexpected_resp0", 1, 0);
                else check("resp_data0", 32'(resp_data0), 32'(q0.pop_front()));
                served.push_back(1'b0);
            end
            if (resp_valid1 && resp_ready1) begin
                if (q1.size() == 0) check("unexpected_resp1", 1, 0);
                else check("resp_data1", 32'(resp_data1), 32'(q1.pop_front()));
                served.push_back(1'b1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_req(input bit port, input logic [3:0] addr, input logic [3:0] exp,
                          input int max_wait);
        int  w   = 0;
        bit  got = 0;
        if (port) begin req_valid1 = 1'b1; req_addr1 = addr; end
        else      begin req_valid0 = 1'b1; req_addr0 = addr; end
        while (!got && w < 200) begin
            @(negedge clk);
            if ((port ? req_ready1 : req_ready0) === 1'b1) got = 1;
            else w++;
        end
        if (got) begin
            if (port) q1.push_back(exp); else q0.push_back(exp);
            check(port ? "wait_bound1" : "wait_bound0", 32'(w <= max_wait), 1);
        end else begin
            check(port ? "req_timeout1" : "req_timeout0", 0, 1);
        end
        @(posedge clk); #1;
        if (port) req_valid1 = 1'b0; else req_valid0 = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(q0.size() + q1.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic soak_port(input bit port, input int count, input int max_wait);
        logic [3:0] a;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 4'($urandom_range(0, 15));
            do_req(port, a, a ^ 4'hA, max_wait);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid0 = 0; req_valid1 = 0; req_addr0 = 0; req_addr1 = 0;
        resp_ready0 = 1; resp_ready1 = 1; soak_done = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        apply_reset();

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'({req_ready0, req_ready1}), 0);
        check("rst_resp_valid", 32'({resp_valid0, resp_valid1}), 0);
        check("rst_rom", 32'({rom_address, rom_en, rom_read_en}), 0);
        @(posedge clk); #1;

        // Single request with exact latency
        do_req(0, 4'h3, 4'h9, 0);
        @(negedge clk);
        check("issue_rom_en", 32'({rom_en, rom_read_en}), 32'b11);
        check("issue_rom_addr", 32'(rom_address), 32'h3);
        @(negedge clk);
        check("resp_valid0_latency", 32'(resp_valid0), 1);
        check("resp_data0_latency", 32'(resp_data0), 32'h9);
        @(posedge clk); #1;
        wait_drain();

        // Contention after reset: alternating order
        apply_reset();
        served.delete();
        fork
            do_req(0, 4'h1, 4'hB, 6);
            do_req(1, 4'h2, 4'h8, 6);
        join
        fork
            do_req(0, 4'h1, 4'hB, 6);
            do_req(1, 4'h2, 4'h8, 6);
        join
        wait_drain();
        check("order_count", 32'(served.size()), 4);
        if (served.size() == 4) begin
            check("order0", 32'(served[0]), 0);
            check("order1", 32'(served[1]), 1);
            check("order2", 32'(served[2]), 0);
            check("order3", 32'(served[3]), 1);
        end

        // Backpressure on requester 1 while requester 0 waits
        served.delete();
        resp_ready1 = 1'b0;
        do_req(1, 4'h5, 4'hF, 0);
        req_valid0 = 1'b1; req_addr0 = 4'h0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid1", 32'(resp_valid1), 1);
            check("bp_resp_data1", 32'(resp_data1), 32'hF);
            check("bp_req_ready0", 32'(req_ready0), 0);
            check("bp_rom_en", 32'(rom_en), 0);
        end
        @(posedge clk); #1;
        resp_ready1 = 1'b1;
        do_req(0, 4'h0, 4'hA, 3);
        wait_drain();
        check("bp_order_count", 32'(served.size()), 2);
        if (served.size() == 2) check("bp_first", 32'(served[0]), 1);

        // Reset during ISSUE; priority was 1 before reset
        req_valid0 = 1'b1; req_addr0 = 4'h7;
        @(negedge clk);
        check("mid_req_ready0", 32'(req_ready0), 1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_issue_rom_en", 32'(rom_en), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_outputs",
                  32'({req_ready0, req_ready1, resp_valid0, resp_valid1, rom_en, rom_read_en, rom_address}), 0);
        end
        @(posedge clk); #1;
        served.delete();
        fork
            do_req(0, 4'h4, 4'hE, 6);
            do_req(1, 4'h6, 4'hC, 6);
        join
        wait_drain();
        if (served.size() == 2) check("prio_after_rst", 32'(served[0]), 0);
        else check("prio_after_rst_count", 32'(served.size()), 2);

        // Address extremes
        do_req(0, 4'h0, 4'hA, 0);
        wait_drain();
        do_req(1, 4'hF, 4'h5, 0);
        wait_drain();
        @(negedge clk);
        check("idle_rom_addr", 32'({rom_address, rom_en}), 0);
        @(posedge clk); #1;

        // Soak with random backpressure
        fork
            begin
                fork
                    soak_port(0, 150, 200);
                    soak_port(1, 150, 200);
                join
                soak_done = 1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk); #1;
                    resp_ready0 = 1'($urandom_range(0, 1));
                    resp_ready1 = 1'($urandom_range(0, 1));
                end
            end
        join
        resp_ready0 = 1'b1; resp_ready1 = 1'b1;
        wait_drain();

        // Soak with responses always taken: wait bound of 6 cycles
        fork
            soak_port(0, 100, 6);
            soak_port(1, 100, 6);
        join
        wait_drain();

        check("q0_empty", 32'(q0.size()), 0);
        check("q1_empty", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
